// File: rtl/imem_loader.sv
// imem_loader: loads the instruction memory from a length-prefixed,
// big-endian byte stream, then fills the rest of the memory with FILL_WORD.
// The processor is held stalled for the whole session.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for start; processor runs
// S_LEN_HI | waiting for length byte N[15:8]
// S_LEN_LO | waiting for length byte N[7:0]; range check on N
// S_DATA   | assembling data words, one write per 4 bytes
// S_FILL   | writing FILL_WORD to addresses N..D-1, one per cycle
// S_FIN    | one-cycle wrap-up; done is set on leaving
module imem_loader #(
  parameter int          PC_SIZE   = 8,
  parameter logic [31:0] FILL_WORD = 32'hffffffff
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               mem_we,
  output logic [PC_SIZE-1:0] mem_addr,
  output logic [31:0]        mem_wdata,
  output logic               cpu_hold,
  output logic               done,
  output logic               err,
  output logic [PC_SIZE:0]   word_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_FILL, S_FIN
  } state_t;

  // Depth held at 32 bits so that N = D is representable and comparable.
  localparam logic [31:0]        DEPTH     = 32'd1 << PC_SIZE;
  localparam logic [PC_SIZE-1:0] LAST_ADDR = '1;

  state_t             state, state_nxt;
  logic [15:0]        len;
  logic [23:0]        asm_word;
  logic [1:0]         byte_cnt;
  logic [PC_SIZE-1:0] wr_ptr;

  logic        xfer;
  logic [31:0] len_rx;
  logic        len_bad;
  logic        len_zero;
  logic        len_full;
  logic        word_last;

  assign xfer      = in_valid && in_ready;
  assign len_rx    = {16'd0, len[15:8], in_data};
  assign len_bad   = len_rx > DEPTH;
  assign len_zero  = len_rx == 32'd0;
  assign len_full  = {16'd0, len} == DEPTH;
  assign word_last = (32'(word_count) + 32'd1) == {16'd0, len};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decision.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_LEN_HI;
      S_LEN_HI: if (xfer)  state_nxt = S_LEN_LO;
      S_LEN_LO: if (xfer) begin
        if (len_bad)       state_nxt = S_IDLE;
        else if (len_zero) state_nxt = S_FILL;
        else               state_nxt = S_DATA;
      end
      S_DATA:   if (xfer && byte_cnt == 2'd3 && word_last)
                  state_nxt = len_full ? S_FIN : S_FILL;
      S_FILL:   if (wr_ptr == LAST_ADDR) state_nxt = S_FIN;
      S_FIN:    state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Handshake and stall outputs decoded from state.
  always_comb begin
    in_ready = 1'b0;
    cpu_hold = 1'b1;
    case (state)
      S_IDLE:                    cpu_hold = 1'b0;
      S_LEN_HI, S_LEN_LO, S_DATA: in_ready = 1'b1;
      default: ;
    endcase
  end

  // Datapath: length capture, word assembly, registered memory writes, status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len        <= '0;
      asm_word   <= '0;
      byte_cnt   <= '0;
      wr_ptr     <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      word_count <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          done       <= 1'b0;
          err        <= 1'b0;
          word_count <= '0;
          byte_cnt   <= '0;
          wr_ptr     <= '0;
        end
        S_LEN_HI: if (xfer) len[15:8] <= in_data;
        S_LEN_LO: if (xfer) begin
          len[7:0] <= in_data;
          if (len_bad) err <= 1'b1;
        end
        S_DATA: if (xfer) begin
          byte_cnt <= byte_cnt + 2'd1;
          asm_word <= {asm_word[15:0], in_data};
          if (byte_cnt == 2'd3) begin
            mem_we     <= 1'b1;
            mem_addr   <= wr_ptr;
            mem_wdata  <= {asm_word, in_data};
            wr_ptr     <= wr_ptr + 1'b1;
            word_count <= word_count + 1'b1;
          end
        end
        S_FILL: begin
          mem_we    <= 1'b1;
          mem_addr  <= wr_ptr;
          mem_wdata <= FILL_WORD;
          wr_ptr    <= wr_ptr + 1'b1;
        end
        S_FIN: done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream program loader that writes the instruction memory from outside the core. It accepts a length-prefixed, big-endian byte stream over a valid/ready handshake and assembles 32-bit instruction words. It writes those words to consecutive instruction-memory addresses from 0, then fills every remaining address with the garbage word. It holds the processor stalled for the whole session and flags completion.

## Interface
- PC_SIZE, 8, instruction-memory address width; depth D = 2^PC_SIZE words
- FILL_WORD, 32'hffffffff, word written to every address not covered by the program
- clk  in  1  single clock, all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that begins a load session; honoured only in IDLE
- in_valid  in  1  byte available on in_data
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts a byte; a transfer occurs on an edge where in_valid && in_ready
- mem_we  out  1  registered instruction-memory write enable
- mem_addr  out  PC_SIZE  registered write address
- mem_wdata  out  32  registered write data
- cpu_hold  out  1  stall/hold for the processor while loading
- done  out  1  sticky; set when a session completes, cleared by the next accepted start
- err  out  1  sticky; set when the length exceeds D, cleared by the next accepted start
- word_count  out  PC_SIZE+1  data words written in the current or last session

## Operation
- Stream format: 2 length bytes forming N[15:0], high byte first. Then 4·N data bytes; each word is big-endian, so the first byte is [31:24] and the fourth is [7:0].
- States: IDLE, LEN_HI, LEN_LO, DATA, FILL, FIN.
- IDLE: in_ready=0, cpu_hold=0. When start=1 → LEN_HI; clear done, err, word_count, byte and word counters.
- LEN_HI: in_ready=1. A transfer captures N[15:8] → LEN_LO.
- LEN_LO: in_ready=1. A transfer captures N[7:0], then:
  - N > D: set err → IDLE, with no memory write and done stays 0.
  - N = 0: → FILL starting at address 0.
  - Otherwise: → DATA.
- DATA: in_ready=1. Each transfer shifts the byte into the assembly register. On the 4th byte of a word, the same edge loads mem_we=1, mem_addr=word index, and the assembled word; then word index and word_count increment. After word N-1: → FILL if N < D, else → FIN.
- FILL: in_ready=0. One write per cycle of FILL_WORD to addresses N..D-1 in ascending order, then → FIN.
- FIN: one cycle, mem_we=0, cpu_hold=1 → IDLE. The same edge sets done=1.
- cpu_hold=1 in every state except IDLE.
- mem_we is never high for two cycles with the same address. Addresses are written strictly ascending with no gaps, so exactly D writes occur per successful session.
- start outside IDLE is ignored. in_valid outside LEN_HI/LEN_LO/DATA is ignored, and those bytes are not consumed.
- Arithmetic: compare N against D at PC_SIZE+1 bits or wider, so N = D is legal and N = D+1 sets err. mem_addr wraps never: fill stops at D-1.

## Timing
- Reset (async, immediate on rst_n=0): state=IDLE; in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, done=0, err=0, word_count=0.
- Reset mid-session aborts with no further writes. Memory content is left as partially written.
- Latency: 4th byte of a word accepted at edge k → mem_we high during cycle k..k+1, and the memory captures the word at edge k+1.
- No backpressure in DATA. A byte may be accepted every cycle, one word per 4 cycles at full rate. Gaps in in_valid stall assembly only.
- First fill write is in the cycle after the last data write; fill takes D-N consecutive cycles.
- FIN follows the last write cycle. done rises and cpu_hold falls on the same edge, after the last write has been captured.

## Test plan
- Reset: drive stream bytes with rst_n=0 → all outputs 0, in_ready=0, no mem_we.
- Load N=6 with words 8C010000, 8C020001, 8C030002, 0022183F, 00221800, AC030003 at full rate → addresses 0..5 written with those words in order. Addresses 6..255 are then written with FFFFFFFF, one per cycle. done=1, word_count=6, err=0, cpu_hold low after FIN.
- N=0 → 256 consecutive writes of FFFFFFFF to addresses 0..255, then done=1 and word_count=0.
- N=257 (bytes 01,01) → err=1, done=0, zero mem_we pulses, back to IDLE. N=256 → 256 data writes with no fill cycles.
- Random in_valid gaps plus a start pulse during DATA → written words are identical to the gap-free run, and the extra start has no effect.
- rst_n pulsed low after 2 of 4 data words → outputs reset immediately. A following full session for N=1 succeeds: address 0 gets the word, 1..255 are filled, done=1.
